// File: rtl/ase_hssi_loopback_emul.sv
// HSSI loopback emulator: per-channel AXI-S TX sink with optional FIFO
// replay onto RX, frame counting and sticky zero-tkeep error flags.
module ase_hssi_loopback_emul #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int LOOPBACK = 1,
  parameter int CNT_W    = 32
) (
  input  logic                         pClk,
  input  logic                         softReset,
  input  logic [NUM_CH-1:0]            tx_tvalid,
  output logic [NUM_CH-1:0]            tx_tready,
  input  logic [NUM_CH*DATA_W-1:0]     tx_tdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   tx_tkeep,
  input  logic [NUM_CH-1:0]            tx_tlast,
  output logic [NUM_CH-1:0]            rx_tvalid,
  input  logic [NUM_CH-1:0]            rx_tready,
  output logic [NUM_CH*DATA_W-1:0]     rx_tdata,
  output logic [NUM_CH*DATA_W/8-1:0]   rx_tkeep,
  output logic [NUM_CH-1:0]            rx_tlast,
  input  logic [NUM_CH-1:0]            pause,
  output logic [NUM_CH*CNT_W-1:0]      frame_cnt,
  output logic [NUM_CH-1:0]            err_keep
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int OW     = AW + 1;
  localparam int BEAT_W = DATA_W + KEEP_W + 1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e            state_q, state_d;
    logic              full;
    logic              ready;
    logic              accept;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [KEEP_W-1:0] keep_in;

    assign keep_in      = tx_tkeep[c*KEEP_W +: KEEP_W];
    assign accept       = tx_tvalid[c] & ready;
    assign tx_tready[c] = ready;

    // Frame-boundary state register
    always_ff @(posedge pClk) begin
      if (softReset) state_q <= ST_IDLE;
      else           state_q <= state_d;
    end

    // Next state: every accepted beat lands on a boundary iff it carries tlast
    always_comb begin
      state_d = state_q;
      if (accept) state_d = tx_tlast[c] ? ST_IDLE : ST_IN_FRAME;
    end

    // Ready depends only on registered state, occupancy and pause; pause only
    // holds off the start of a new frame
    always_comb begin
      ready = 1'b0;
      if (!softReset) ready = !full && !(pause[c] && (state_q == ST_IDLE));
    end

    // Saturating frame counter and sticky empty-keep flag
    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (accept && tx_tlast[c] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if (accept && (keep_in == '0))              err_d = 1'b1;
    end

    // Counter / error registers
    always_ff @(posedge pClk) begin
      if (softReset) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign frame_cnt[c*CNT_W +: CNT_W] = cnt_q;
    assign err_keep[c]                 = err_q;

    if (LOOPBACK != 0) begin : g_fifo
      logic [BEAT_W-1:0] mem_q [DEPTH];
      logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
      logic [OW-1:0]     occ_q, occ_d;
      logic              valid;
      logic              pop;
      logic [BEAT_W-1:0] head;

      // full uses start-of-cycle occupancy, so a same-cycle pop never frees a slot
      assign full  = (occ_q == OW'(DEPTH));
      assign valid = !softReset && (occ_q != '0);
      assign pop   = valid & rx_tready[c];
      assign head  = mem_q[rd_ptr_q];

      assign rx_tvalid[c]                  = valid;
      assign rx_tdata[c*DATA_W +: DATA_W]  = head[BEAT_W-1 -: DATA_W];
      assign rx_tkeep[c*KEEP_W +: KEEP_W]  = head[KEEP_W:1];
      assign rx_tlast[c]                   = head[0];

      // Pointer and occupancy update; pointers wrap naturally at DEPTH
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
        if (accept && !pop)      occ_d = occ_q + OW'(1);
        else if (!accept && pop) occ_d = occ_q - OW'(1);
      end

      // FIFO control registers
      always_ff @(posedge pClk) begin
        if (softReset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          occ_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          occ_q    <= occ_d;
        end
      end

      // Beat storage, not reset
      always_ff @(posedge pClk) begin
        if (accept) mem_q[wr_ptr_q] <= {tx_tdata[c*DATA_W +: DATA_W], keep_in, tx_tlast[c]};
      end
    end else begin : g_sink
      assign full                          = 1'b0;
      assign rx_tvalid[c]                  = 1'b0;
      assign rx_tdata[c*DATA_W +: DATA_W]  = '0;
      assign rx_tkeep[c*KEEP_W +: KEEP_W]  = '0;
      assign rx_tlast[c]                   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ase_hssi_loopback_emul.sv
// Bench for ase_hssi_loopback_emul: a loopback instance checked against a
// queue-based channel model, plus a sink-mode instance with 4-bit counters.
module tb_ase_hssi_loopback_emul;

  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int DEP = 16;
  localparam int CW  = 32;
  localparam int SCW = 4;
  localparam int BW  = DW + KW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]    tx_tvalid, tx_tready, tx_tlast, rx_tvalid, rx_tready, rx_tlast, pause, err_keep;
  logic [NCH*DW-1:0] tx_tdata, rx_tdata;
  logic [NCH*KW-1:0] tx_tkeep, rx_tkeep;
  logic [NCH*CW-1:0] frame_cnt;

  logic [NCH-1:0]     s_tx_tvalid, s_tx_tready, s_tx_tlast, s_rx_tvalid, s_rx_tready, s_rx_tlast, s_pause, s_err_keep;
  logic [NCH*DW-1:0]  s_tx_tdata, s_rx_tdata;
  logic [NCH*KW-1:0]  s_tx_tkeep, s_rx_tkeep;
  logic [NCH*SCW-1:0] s_frame_cnt;

  ase_hssi_loopback_emul #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .LOOPBACK(1), .CNT_W(CW)) dut (
    .pClk(clk), .softReset(rst),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
    .pause(pause), .frame_cnt(frame_cnt), .err_keep(err_keep)
  );

  ase_hssi_loopback_emul #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .LOOPBACK(0), .CNT_W(SCW)) dut_s (
    .pClk(clk), .softReset(rst),
    .tx_tvalid(s_tx_tvalid), .tx_tready(s_tx_tready), .tx_tdata(s_tx_tdata), .tx_tkeep(s_tx_tkeep), .tx_tlast(s_tx_tlast),
    .rx_tvalid(s_rx_tvalid), .rx_tready(s_rx_tready), .rx_tdata(s_rx_tdata), .rx_tkeep(s_rx_tkeep), .rx_tlast(s_rx_tlast),
    .pause(s_pause), .frame_cnt(s_frame_cnt), .err_keep(s_err_keep)
  );

  int errors = 0;
  int checks = 0;

  // Channel model for the loopback instance: a FIFO of beats per channel
  logic [BW-1:0] mq [NCH][$];
  logic          m_inf [NCH];
  logic [CW-1:0] m_cnt [NCH];
  logic          m_err [NCH];

  function automatic logic exp_ready(int c);
    return !rst && (mq[c].size() < DEP) && !(pause[c] && !m_inf[c]);
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      logic acc, pop;
      if (rst) begin
        mq[c].delete();
        m_inf[c] = 1'b0;
        m_cnt[c] = '0;
        m_err[c] = 1'b0;
      end else begin
        acc = tx_tvalid[c] && exp_ready(c);
        pop = (mq[c].size() > 0) && rx_tready[c];
        if (pop) void'(mq[c].pop_front());
        if (acc) begin
          mq[c].push_back({tx_tdata[c*DW +: DW], tx_tkeep[c*KW +: KW], tx_tlast[c]});
          m_inf[c] = !tx_tlast[c];
          if (tx_tlast[c] && m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + 1;
          if (tx_tkeep[c*KW +: KW] == '0) m_err[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_tvalid = '1; tx_tlast = '1; tx_tkeep = '1; tx_tdata = '0; rx_tready = '1; pause = '0;
    s_tx_tvalid = '1; s_tx_tlast = '1; s_tx_tkeep = '1; s_tx_tdata = '0; s_rx_tready = '1; s_pause = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (tx_tready !== '0) begin errors++; $display("FAIL reset_tx_tready got=%b exp=0000", tx_tready); end
      checks++; if (rx_tvalid !== '0) begin errors++; $display("FAIL reset_rx_tvalid got=%b exp=0000", rx_tvalid); end
      checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt); end
      checks++; if (err_keep !== '0) begin errors++; $display("FAIL reset_err_keep got=%b exp=0000", err_keep); end
      checks++; if (s_tx_tready !== '0) begin errors++; $display("FAIL reset_sink_tready got=%b exp=0000", s_tx_tready); end
      checks++; if (s_frame_cnt !== '0) begin errors++; $display("FAIL reset_sink_cnt got=%h exp=0", s_frame_cnt); end
      advance();
    end
    rst = 1'b0; tx_tvalid = '0; s_tx_tvalid = '0;
    @(negedge clk);
    checks++; if (tx_tready !== '1) begin errors++; $display("FAIL post_reset_tready got=%b exp=1111", tx_tready); end
    checks++; if (s_tx_tready !== '1) begin errors++; $display("FAIL post_reset_sink_tready got=%b exp=1111", s_tx_tready); end
    advance();
  endtask

  task automatic test_frame();
    logic [63:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    rx_tready = '1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        tx_tvalid[0] = 1'b1; tx_tdata[63:0] = vals[i]; tx_tkeep[7:0] = 8'hFF; tx_tlast[0] = (i == 2);
      end else tx_tvalid[0] = 1'b0;
      @(negedge clk);
      if (i < 3) begin
        checks++; if (tx_tready[0] !== 1'b1) begin errors++; $display("FAIL frame_tready beat%0d got=%b exp=1", i, tx_tready[0]); end
      end
      if (i == 0) begin
        checks++; if (rx_tvalid[0] !== 1'b0) begin errors++; $display("FAIL frame_rx_early got=%b exp=0", rx_tvalid[0]); end
      end else begin
        checks++; if (rx_tvalid[0] !== 1'b1) begin errors++; $display("FAIL frame_rx_valid beat%0d got=%b exp=1", i-1, rx_tvalid[0]); end
        checks++; if (rx_tdata[63:0] !== vals[i-1]) begin errors++; $display("FAIL frame_rx_data beat%0d got=%h exp=%h", i-1, rx_tdata[63:0], vals[i-1]); end
        checks++; if (rx_tkeep[7:0] !== 8'hFF) begin errors++; $display("FAIL frame_rx_keep beat%0d got=%h exp=ff", i-1, rx_tkeep[7:0]); end
        checks++; if (rx_tlast[0] !== (i == 3)) begin errors++; $display("FAIL frame_rx_last beat%0d got=%b exp=%b", i-1, rx_tlast[0], (i == 3)); end
      end
      checks++; if (rx_tvalid[3:1] !== 3'b000) begin errors++; $display("FAIL frame_other_idle got=%b exp=000", rx_tvalid[3:1]); end
      advance();
    end
    @(negedge clk);
    checks++; if (rx_tvalid[0] !== 1'b0) begin errors++; $display("FAIL frame_rx_drained got=%b exp=0", rx_tvalid[0]); end
    checks++; if (frame_cnt[31:0] !== 32'd1) begin errors++; $display("FAIL frame_cnt0 got=%0d exp=1", frame_cnt[31:0]); end
    checks++; if (frame_cnt[127:32] !== '0) begin errors++; $display("FAIL frame_cnt_others got=%h exp=0", frame_cnt[127:32]); end
    advance();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int dut_acc = 0;
    rx_tready[1] = 1'b0; tx_tvalid[1] = 1'b1; tx_tkeep[15:8] = 8'hFF; tx_tlast[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tx_tdata[127:64] = 64'hB000 + acc;
      @(negedge clk);
      checks++; if (tx_tready[1] !== (acc < 16)) begin errors++; $display("FAIL bp_tready cyc%0d got=%b exp=%b", k, tx_tready[1], (acc < 16)); end
      if (tx_tready[1] === 1'b1) dut_acc++;
      if (acc < 16) acc++;
      advance();
    end
    checks++; if (dut_acc != 16) begin errors++; $display("FAIL bp_accepted got=%0d exp=16", dut_acc); end
    tx_tvalid[1] = 1'b0; rx_tready[1] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) begin
        checks++; if (tx_tready[1] !== 1'b0) begin errors++; $display("FAIL bp_still_full got=%b exp=0", tx_tready[1]); end
      end
      if (j == 1) begin
        checks++; if (tx_tready[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_return got=%b exp=1", tx_tready[1]); end
      end
      checks++; if (rx_tvalid[1] !== 1'b1 || rx_tdata[127:64] !== 64'hB000 + j) begin
        errors++; $display("FAIL bp_drain beat%0d got=%b/%h exp=1/%h", j, rx_tvalid[1], rx_tdata[127:64], 64'hB000 + j);
      end
      advance();
    end
    @(negedge clk);
    checks++; if (rx_tvalid[1] !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", rx_tvalid[1]); end
    advance();
  endtask

  task automatic test_pause();
    rx_tready[2] = 1'b1; pause[2] = 1'b0; tx_tvalid[2] = 1'b1; tx_tkeep[23:16] = 8'hFF;
    for (int b = 1; b <= 4; b++) begin
      tx_tdata[191:128] = 64'hC0 + b; tx_tlast[2] = (b == 4);
      @(negedge clk);
      checks++; if (tx_tready[2] !== 1'b1) begin errors++; $display("FAIL pause_in_frame beat%0d got=%b exp=1", b, tx_tready[2]); end
      advance();
      if (b == 1) pause[2] = 1'b1;
    end
    tx_tdata[191:128] = 64'hC9; tx_tlast[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (tx_tready[2] !== 1'b0) begin errors++; $display("FAIL pause_hold cyc%0d got=%b exp=0", k, tx_tready[2]); end
      advance();
    end
    checks++; if (frame_cnt[95:64] !== 32'd1) begin errors++; $display("FAIL pause_cnt got=%0d exp=1", frame_cnt[95:64]); end
    pause[2] = 1'b0;
    @(negedge clk);
    checks++; if (tx_tready[2] !== 1'b1) begin errors++; $display("FAIL pause_release got=%b exp=1", tx_tready[2]); end
    advance();
    tx_tvalid[2] = 1'b0;
    repeat (3) advance();
  endtask

  task automatic test_keep_err_reset();
    rx_tready[0] = 1'b0; tx_tvalid[0] = 1'b1; tx_tlast[0] = 1'b0; tx_tkeep[7:0] = 8'h00; tx_tdata[63:0] = 64'hD0;
    @(negedge clk);
    checks++; if (err_keep[0] !== 1'b0) begin errors++; $display("FAIL keep_err_pre got=%b exp=0", err_keep[0]); end
    advance();
    tx_tkeep[7:0] = 8'h0F;
    for (int k = 1; k <= 4; k++) begin
      tx_tdata[63:0] = 64'hD0 + k;
      @(negedge clk);
      checks++; if (err_keep[0] !== 1'b1) begin errors++; $display("FAIL keep_err_sticky cyc%0d got=%b exp=1", k, err_keep[0]); end
      advance();
    end
    tx_tvalid[0] = 1'b0;
    @(negedge clk);
    checks++; if (rx_tvalid[0] !== 1'b1 || rx_tkeep[7:0] !== 8'h00 || rx_tdata[63:0] !== 64'hD0) begin
      errors++; $display("FAIL keep_err_stored got=%b/%h/%h exp=1/00/d0", rx_tvalid[0], rx_tkeep[7:0], rx_tdata[63:0]);
    end
    advance();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_tready !== '0 || rx_tvalid !== '0) begin errors++; $display("FAIL midreset_outputs got=%b/%b exp=0000/0000", tx_tready, rx_tvalid); end
    advance();
    rst = 1'b0; pause[0] = 1'b1;
    @(negedge clk);
    checks++; if (rx_tvalid !== '0) begin errors++; $display("FAIL midreset_flushed got=%b exp=0000", rx_tvalid); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL midreset_cnt got=%h exp=0", frame_cnt); end
    checks++; if (err_keep !== '0) begin errors++; $display("FAIL midreset_err got=%b exp=0000", err_keep); end
    checks++; if (tx_tready !== 4'b1110) begin errors++; $display("FAIL midreset_idle_tready got=%b exp=1110", tx_tready); end
    advance();
    pause = '0; rx_tready = '1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        tx_tvalid[c] = ($urandom_range(0, 9) < 7);
        tx_tdata[c*DW +: DW] = {$urandom, $urandom};
        tx_tkeep[c*KW +: KW] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
        tx_tlast[c] = ($urandom_range(0, 3) == 0);
        pause[c] = ($urandom_range(0, 7) == 0);
        rx_tready[c] = (cyc < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        logic ev;
        logic [BW-1:0] got;
        ev = !rst && (mq[c].size() > 0);
        got = {rx_tdata[c*DW +: DW], rx_tkeep[c*KW +: KW], rx_tlast[c]};
        checks++; if (tx_tready[c] !== exp_ready(c)) begin errors++; $display("FAIL rnd_tready cyc%0d ch%0d got=%b exp=%b", cyc, c, tx_tready[c], exp_ready(c)); end
        checks++; if (rx_tvalid[c] !== ev) begin errors++; $display("FAIL rnd_rx_valid cyc%0d ch%0d got=%b exp=%b", cyc, c, rx_tvalid[c], ev); end
        if (ev) begin
          checks++; if (got !== mq[c][0]) begin errors++; $display("FAIL rnd_rx_beat cyc%0d ch%0d got=%h exp=%h", cyc, c, got, mq[c][0]); end
        end
        checks++; if (frame_cnt[c*CW +: CW] !== m_cnt[c]) begin errors++; $display("FAIL rnd_cnt cyc%0d ch%0d got=%0d exp=%0d", cyc, c, frame_cnt[c*CW +: CW], m_cnt[c]); end
        checks++; if (err_keep[c] !== m_err[c]) begin errors++; $display("FAIL rnd_err cyc%0d ch%0d got=%b exp=%b", cyc, c, err_keep[c], m_err[c]); end
      end
      advance();
    end
    tx_tvalid = '0; pause = '0; rx_tready = '1;
    repeat (DEP + 2) advance();
  endtask

  task automatic test_sink();
    s_tx_tvalid[3] = 1'b1; s_tx_tkeep[31:24] = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      s_tx_tdata[255:192] = {$urandom, $urandom}; s_tx_tlast[3] = k[0];
      @(negedge clk);
      checks++; if (s_tx_tready[3] !== 1'b1) begin errors++; $display("FAIL sink_tready beat%0d got=%b exp=1", k, s_tx_tready[3]); end
      checks++; if (s_rx_tvalid !== '0) begin errors++; $display("FAIL sink_rx_valid beat%0d got=%b exp=0000", k, s_rx_tvalid); end
      advance();
    end
    s_tx_tvalid[3] = 1'b0; s_pause[3] = 1'b1;
    @(negedge clk);
    checks++; if (s_frame_cnt[15:12] !== 4'd5) begin errors++; $display("FAIL sink_cnt got=%0d exp=5", s_frame_cnt[15:12]); end
    checks++; if (s_rx_tvalid !== '0 || s_rx_tdata !== '0) begin errors++; $display("FAIL sink_rx_tied got=%b/%h exp=0/0", s_rx_tvalid, s_rx_tdata); end
    checks++; if (s_tx_tready[3] !== 1'b0) begin errors++; $display("FAIL sink_pause got=%b exp=0", s_tx_tready[3]); end
    advance();
    s_pause[3] = 1'b0;
  endtask

  task automatic test_saturate();
    s_tx_tvalid[0] = 1'b1; s_tx_tlast[0] = 1'b1; s_tx_tkeep[7:0] = 8'hFF;
    for (int k = 0; k < 17; k++) begin
      s_tx_tdata[63:0] = 64'(k);
      @(negedge clk);
      if (k == 14) begin
        checks++; if (s_frame_cnt[3:0] !== 4'd14) begin errors++; $display("FAIL sat_mid got=%0d exp=14", s_frame_cnt[3:0]); end
      end
      advance();
    end
    s_tx_tvalid[0] = 1'b0;
    @(negedge clk);
    checks++; if (s_frame_cnt[3:0] !== 4'd15) begin errors++; $display("FAIL sat_final got=%0d exp=15", s_frame_cnt[3:0]); end
    checks++; if (s_err_keep !== '0) begin errors++; $display("FAIL sat_err got=%b exp=0000", s_err_keep); end
    advance();
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_inf[c] = 1'b0; m_cnt[c] = '0; m_err[c] = 1'b0;
    end
    test_reset();
    test_frame();
    test_backpressure();
    test_pause();
    test_keep_err_reset();
    test_random();
    test_sink();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
